channel_link_out_buf: RTL and testbench
=======================================

Name: channel_link_out_buf

Overview:
- Parametrised, buffered successor to the DAQ channel-link output stage.
- Accepts frame words from the DAQ event builder and holds them in an internal elastic FIFO.
- Drives them onto the motherboard channel link with registered outputs, honouring a motherboard FIFO-full back-pressure input.
- Generates data-available, end-word and overlap flags per word, and reports overflow.

Parameters:
DATA_W, 16, frame word width.
DEPTH, 16, elastic FIFO depth in words; power of 2, minimum 4.
OVLP_BIT, 14, index of the FRAME_DATA bit that drives OVLPMUX; must be < DATA_W.

Ports:
CLK  in  1  system clock; all logic rising-edge.
RST  in  1  asynchronous, active-high reset.
L1A_MATCH  in  1  L1A matched to this board.
DVALID  in  1  FRAME_DATA/LAST_WRD/MLT_OVLP valid this cycle.
LAST_WRD  in  1  final word of the event.
MLT_OVLP  in  1  multiple-overlap flag for the word.
FRAME_DATA  in  DATA_W  frame word.
MB_FIFO_FULL_B  in  1  motherboard FIFO full, active low (0 = full).
DATAOUT  out  DATA_W  registered link data.
MB_FIFO_PUSH_B  out  1  active-low push strobe, one cycle per word.
MOVLP  out  1  stored MLT_OVLP of the word on DATAOUT.
OVLPMUX  out  1  inverted DATAOUT[OVLP_BIT].
DATAAVAIL  out  1  L1A_MATCH delayed one cycle.
ENDWORD  out  1  high with the pushed word flagged LAST_WRD.
FIFO_OVF  out  1  sticky overflow flag.
OCC  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (async):
  - DATAOUT=0, MB_FIFO_PUSH_B=1, MOVLP=0, OVLPMUX=1, DATAAVAIL=0, ENDWORD=0, FIFO_OVF=0, OCC=0.
  - Pointers are cleared and FSM returns to IDLE.
  - Reset mid-event discards all buffered words; no partial push completes.
- Write side:
  - On DVALID with OCC<DEPTH, store {LAST_WRD, MLT_OVLP, FRAME_DATA} at the write pointer.
  - On DVALID with OCC==DEPTH (and no pop that cycle), drop the word and set FIFO_OVF=1.
  - FIFO_OVF clears only on RST.
  - Pointers are modulo DEPTH and wrap freely.
- Read FSM:
  - IDLE: entered from reset or when the FIFO is empty. Go to XMIT when OCC>0 and MB_FIFO_FULL_B=1.
  - XMIT:
    - A pop occurs each cycle with OCC>0 and MB_FIFO_FULL_B=1.
    - Next cycle: DATAOUT=word, MOVLP=flag, OVLPMUX=~word[OVLP_BIT], ENDWORD=last, MB_FIFO_PUSH_B=0.
    - Go to STALL if MB_FIFO_FULL_B=0. Go to IDLE if the FIFO becomes empty.
  - STALL: no pop, MB_FIFO_PUSH_B=1. Return to XMIT when MB_FIFO_FULL_B=1.
- Latency and hold:
  - Write-to-push latency is 2 cycles from DVALID into an empty FIFO with no back-pressure.
  - One word per cycle sustained throughput.
  - When no push occurs, DATAOUT/MOVLP/OVLPMUX hold their last value, ENDWORD=0, MB_FIFO_PUSH_B=1.
- Occupancy and simultaneity:
  - Simultaneous push and pop leaves OCC unchanged.
  - A write into a full FIFO during a pop is accepted.
  - OCC is exact every cycle: incremented on accepted write, decremented on pop.
- MB_FIFO_FULL_B is sampled combinationally for the pop decision; a word already registered is not recalled.
- DATAAVAIL is registered L1A_MATCH, independent of FIFO state.

Optional Feature:
- Macro CLNK_PARITY_EN.
- Defined:
  - Adds output PAR_OUT (1 bit), registered with DATAOUT, equal to the even parity (XOR) of DATAOUT.
  - PAR_OUT resets to 0 and holds with DATAOUT when no push occurs.
- Undefined: the PAR_OUT port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then 4-word event 0x1111,0x2222,0x4000,0x8001 (LAST on the 4th), MB_FIFO_FULL_B=1 -> four consecutive PUSH_B=0 pulses starting 2 cycles after the first DVALID. OVLPMUX=1,1,0,1. ENDWORD=1 only with 0x8001. OCC returns to 0.
- Pulse L1A_MATCH for 1 cycle -> DATAAVAIL high exactly 1 cycle, one cycle later, regardless of FIFO activity.
- Hold MB_FIFO_FULL_B=0 while writing 6 words, release after 5 cycles -> no pushes while full, OCC peaks at 6, then 6 in-order pushes, FIFO_OVF=0.
- With DEPTH=16 and FULL_B=0, write 17 words -> 17th dropped, FIFO_OVF=1 and sticky, OCC=16; after release exactly 16 words emerge.
- OCC=DEPTH with FULL_B=1 and DVALID each cycle -> simultaneous push/pop, OCC stays 16, no overflow; assert RST mid-stream -> all outputs at reset values immediately, no further pushes.
- CLNK_PARITY_EN defined, push 0x0007 then 0x0003 -> PAR_OUT=1 then 0.

Source files
------------

// File: rtl/channel_link_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : channel_link_out_buf
// Purpose  : Buffers DAQ frame words in an elastic FIFO and drives them onto
//            the motherboard channel link, honouring its FIFO-full back-pressure.
//            Optional macro CLNK_PARITY_EN adds the registered PAR_OUT output.
// Revision : 1.0  initial release
// ============================================================================
module channel_link_out_buf #(
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 16,
   parameter int OVLP_BIT = 14
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       L1A_MATCH,
   input  logic                       DVALID,
   input  logic                       LAST_WRD,
   input  logic                       MLT_OVLP,
   input  logic [DATA_W-1:0]          FRAME_DATA,
   input  logic                       MB_FIFO_FULL_B,
   output logic [DATA_W-1:0]          DATAOUT,
   output logic                       MB_FIFO_PUSH_B,
   output logic                       MOVLP,
   output logic                       OVLPMUX,
   output logic                       DATAAVAIL,
   output logic                       ENDWORD,
   output logic                       FIFO_OVF,
`ifdef CLNK_PARITY_EN
   output logic [$clog2(DEPTH):0]     OCC,
   output logic                       PAR_OUT
`else
   output logic [$clog2(DEPTH):0]     OCC
`endif
);

   localparam int                 c_ptr_w  = $clog2(DEPTH);
   localparam int                 c_word_w = DATA_W + 2;
   localparam logic [c_ptr_w:0]   c_full   = (c_ptr_w+1)'(DEPTH);
   localparam logic [c_ptr_w:0]   c_one    = (c_ptr_w+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_XMIT  = 2'd1,
      S_STALL = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [c_word_w-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0]    r_wr_ptr;
   logic [c_ptr_w-1:0]    r_rd_ptr;
   logic [c_ptr_w:0]      r_occ;

   logic                  w_have;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_wr_acc;
   logic                  w_ovf_set;
   logic [c_word_w-1:0]   w_rd_word;

   assign w_have    = (r_occ != '0);
   assign w_full    = (r_occ == c_full);
   // A full FIFO still accepts a write in the same cycle a word leaves.
   assign w_wr_acc  = DVALID && (!w_full || w_pop);
   assign w_ovf_set = DVALID && w_full && !w_pop;
   assign w_rd_word = r_mem[r_rd_ptr];

   // ---------------------------------------------------------------- storage
   always_ff @(posedge CLK) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= {LAST_WRD, MLT_OVLP, FRAME_DATA};
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         FIFO_OVF <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_wr_acc, w_pop})
            2'b10:   r_occ <= r_occ + c_one;
            2'b01:   r_occ <= r_occ - c_one;
            default: r_occ <= r_occ;
         endcase
         if (w_ovf_set) FIFO_OVF <= 1'b1;
      end
   end

   assign OCC = r_occ;

   // ---------------------------------------------------------------- read FSM
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_have && MB_FIFO_FULL_B) begin
               w_pop       = 1'b1;
               w_state_nxt = S_XMIT;
            end
         end
         S_XMIT: begin
            if (!MB_FIFO_FULL_B) begin
               w_state_nxt = S_STALL;
            end else if (!w_have) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_pop = 1'b1;
               // Last word leaving with nothing arriving empties the FIFO.
               if (r_occ == c_one && !DVALID) w_state_nxt = S_IDLE;
            end
         end
         S_STALL: begin
            if (MB_FIFO_FULL_B) begin
               w_pop       = w_have;
               w_state_nxt = w_have ? S_XMIT : S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- link outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         DATAOUT        <= '0;
         MB_FIFO_PUSH_B <= 1'b1;
         MOVLP          <= 1'b0;
         OVLPMUX        <= 1'b1;
         ENDWORD        <= 1'b0;
         DATAAVAIL      <= 1'b0;
      end else begin
         DATAAVAIL <= L1A_MATCH;
         if (w_pop) begin
            DATAOUT        <= w_rd_word[DATA_W-1:0];
            MOVLP          <= w_rd_word[DATA_W];
            ENDWORD        <= w_rd_word[DATA_W+1];
            OVLPMUX        <= ~w_rd_word[OVLP_BIT];
            MB_FIFO_PUSH_B <= 1'b0;
         end else begin
            ENDWORD        <= 1'b0;
            MB_FIFO_PUSH_B <= 1'b1;
         end
      end
   end

`ifdef CLNK_PARITY_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)        PAR_OUT <= 1'b0;
      else if (w_pop) PAR_OUT <= ^w_rd_word[DATA_W-1:0];
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_channel_link_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_channel_link_out_buf
// Purpose  : Self-checking bench for channel_link_out_buf using a queue model.
// Revision : 1.0  initial release
// ============================================================================
module tb_channel_link_out_buf;

   localparam int DATA_W   = 16;
   localparam int DEPTH    = 16;
   localparam int OVLP_BIT = 14;
   localparam int OW       = $clog2(DEPTH) + 1;

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic              L1A_MATCH = 1'b0;
   logic              DVALID = 1'b0;
   logic              LAST_WRD = 1'b0;
   logic              MLT_OVLP = 1'b0;
   logic [DATA_W-1:0] FRAME_DATA = '0;
   logic              MB_FIFO_FULL_B = 1'b1;
   logic [DATA_W-1:0] DATAOUT;
   logic              MB_FIFO_PUSH_B;
   logic              MOVLP;
   logic              OVLPMUX;
   logic              DATAAVAIL;
   logic              ENDWORD;
   logic              FIFO_OVF;
   logic [OW-1:0]     OCC;
`ifdef CLNK_PARITY_EN
   logic              PAR_OUT;
`endif

   channel_link_out_buf #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .OVLP_BIT (OVLP_BIT)
   ) dut (
      .CLK            (CLK),
      .RST            (RST),
      .L1A_MATCH      (L1A_MATCH),
      .DVALID         (DVALID),
      .LAST_WRD       (LAST_WRD),
      .MLT_OVLP       (MLT_OVLP),
      .FRAME_DATA     (FRAME_DATA),
      .MB_FIFO_FULL_B (MB_FIFO_FULL_B),
      .DATAOUT        (DATAOUT),
      .MB_FIFO_PUSH_B (MB_FIFO_PUSH_B),
      .MOVLP          (MOVLP),
      .OVLPMUX        (OVLPMUX),
      .DATAAVAIL      (DATAAVAIL),
      .ENDWORD        (ENDWORD),
      .FIFO_OVF       (FIFO_OVF),
`ifdef CLNK_PARITY_EN
      .OCC            (OCC),
      .PAR_OUT        (PAR_OUT)
`else
      .OCC            (OCC)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic              last;
      logic              ovlp;
      logic [DATA_W-1:0] data;
   } word_t;

   // Behavioural model: a queue of stored words plus the last pushed word.
   word_t             q[$];
   logic [DATA_W-1:0] m_do;
   logic              m_push_b, m_mov, m_ovm, m_da, m_end, m_ovf, m_par;

   int checks = 0;
   int errors = 0;
   int pushes = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_do = '0; m_push_b = 1'b1; m_mov = 1'b0; m_ovm = 1'b1;
      m_da = 1'b0; m_end = 1'b0; m_ovf = 1'b0; m_par = 1'b0;
   endtask

   task automatic compare_all();
      chk("DATAOUT",   32'(DATAOUT),   32'(m_do));
      chk("PUSH_B",    32'(MB_FIFO_PUSH_B), 32'(m_push_b));
      chk("MOVLP",     32'(MOVLP),     32'(m_mov));
      chk("OVLPMUX",   32'(OVLPMUX),   32'(m_ovm));
      chk("DATAAVAIL", 32'(DATAAVAIL), 32'(m_da));
      chk("ENDWORD",   32'(ENDWORD),   32'(m_end));
      chk("FIFO_OVF",  32'(FIFO_OVF),  32'(m_ovf));
      chk("OCC",       32'(OCC),       32'(q.size()));
`ifdef CLNK_PARITY_EN
      chk("PAR_OUT",   32'(PAR_OUT),   32'(m_par));
`endif
   endtask

   // One clock cycle: drive inputs, advance the model, compare after the edge.
   task automatic step(input logic dv, input logic lw, input logic ov,
                       input logic [DATA_W-1:0] d, input logic fb, input logic l1a);
      word_t w;
      word_t nw;
      bit    pop;
      DVALID = dv; LAST_WRD = lw; MLT_OVLP = ov; FRAME_DATA = d;
      MB_FIFO_FULL_B = fb; L1A_MATCH = l1a;
      pop = (q.size() > 0) && fb;
      if (pop) begin
         w        = q.pop_front();
         m_do     = w.data;
         m_mov    = w.ovlp;
         m_ovm    = ~w.data[OVLP_BIT];
         m_end    = w.last;
         m_par    = ^w.data;
         m_push_b = 1'b0;
      end else begin
         m_end    = 1'b0;
         m_push_b = 1'b1;
      end
      if (dv) begin
         if (q.size() < DEPTH) begin
            nw.last = lw; nw.ovlp = ov; nw.data = d;
            q.push_back(nw);
         end else begin
            m_ovf = 1'b1;
         end
      end
      m_da = l1a;
      @(posedge CLK);
      #1;
      compare_all();
      if (MB_FIFO_PUSH_B == 1'b0) pushes++;
   endtask

   task automatic do_reset(input int hold);
      RST = 1'b1;
      #1;
      chk("rst_DATAOUT",   32'(DATAOUT),        32'h0);
      chk("rst_PUSH_B",    32'(MB_FIFO_PUSH_B), 32'h1);
      chk("rst_MOVLP",     32'(MOVLP),          32'h0);
      chk("rst_OVLPMUX",   32'(OVLPMUX),        32'h1);
      chk("rst_DATAAVAIL", 32'(DATAAVAIL),      32'h0);
      chk("rst_ENDWORD",   32'(ENDWORD),        32'h0);
      chk("rst_FIFO_OVF",  32'(FIFO_OVF),       32'h0);
      chk("rst_OCC",       32'(OCC),            32'h0);
`ifdef CLNK_PARITY_EN
      chk("rst_PAR_OUT",   32'(PAR_OUT),        32'h0);
`endif
      for (int i = 0; i < hold; i++) begin
         @(posedge CLK);
         #1;
         chk("rst_hold_PUSH_B", 32'(MB_FIFO_PUSH_B), 32'h1);
         chk("rst_hold_OCC",    32'(OCC),            32'h0);
      end
      model_reset();
      RST = 1'b0;
   endtask

   initial begin
      logic [DATA_W-1:0] ev_data [4];
      logic              ev_ovm  [4];
      int                p0;
      ev_data[0] = 16'h1111; ev_data[1] = 16'h2222;
      ev_data[2] = 16'h4000; ev_data[3] = 16'h8001;
      ev_ovm[0] = 1'b1; ev_ovm[1] = 1'b1; ev_ovm[2] = 1'b0; ev_ovm[3] = 1'b1;
      model_reset();
      #2;
      do_reset(2);

      // 4-word event, no back-pressure: pushes begin two cycles after the first DVALID.
      for (int k = 0; k < 6; k++) begin
         if (k < 4) step(1'b1, 1'(k == 3), 1'b0, ev_data[k], 1'b1, 1'b0);
         else       step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
         if (k == 0 || k == 5) begin
            chk("ev_push_idle", 32'(MB_FIFO_PUSH_B), 32'h1);
            chk("ev_end_idle",  32'(ENDWORD),        32'h0);
         end else begin
            chk("ev_push",    32'(MB_FIFO_PUSH_B), 32'h0);
            chk("ev_data",    32'(DATAOUT),        32'(ev_data[k-1]));
            chk("ev_ovlpmux", 32'(OVLPMUX),        32'(ev_ovm[k-1]));
            chk("ev_endword", 32'(ENDWORD),        32'(k == 4));
         end
      end
      chk("ev_occ_drained", 32'(OCC), 32'h0);

      // L1A pulse while words flow.
      step(1'b1, 1'b0, 1'b0, 16'h0abc, 1'b1, 1'b1);
      chk("l1a_hi", 32'(DATAAVAIL), 32'h1);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("l1a_lo", 32'(DATAAVAIL), 32'h0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);

      // Back-pressure: 6 words held, then released in order.
      do_reset(1);
      for (int k = 0; k < 6; k++) step(1'b1, 1'(k == 5), 1'b1, 16'(16'ha000 + k), 1'b0, 1'b0);
      chk("bp_no_push", 32'(MB_FIFO_PUSH_B), 32'h1);
      chk("bp_occ_peak", 32'(OCC), 32'h6);
      p0 = pushes;
      for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("bp_push_count", 32'(pushes - p0), 32'h6);
      chk("bp_no_ovf", 32'(FIFO_OVF), 32'h0);

      // Overflow: 17 writes into a blocked FIFO.
      do_reset(1);
      for (int k = 0; k < 17; k++) step(1'b1, 1'b0, 1'b0, 16'(16'h0100 + k), 1'b0, 1'b0);
      chk("ovf_occ", 32'(OCC), 32'(DEPTH));
      chk("ovf_flag", 32'(FIFO_OVF), 32'h1);
      p0 = pushes;
      for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("ovf_push_count", 32'(pushes - p0), 32'(DEPTH));
      chk("ovf_sticky", 32'(FIFO_OVF), 32'h1);

      // Full FIFO streaming: simultaneous push/pop, then reset mid-stream.
      do_reset(1);
      for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b0, 1'b0, 16'(16'h0200 + k), 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b1, 16'(16'h0300 + k), 1'b1, 1'b0);
      chk("stream_occ", 32'(OCC), 32'(DEPTH));
      chk("stream_no_ovf", 32'(FIFO_OVF), 32'h0);
      chk("stream_pushing", 32'(MB_FIFO_PUSH_B), 32'h0);
      do_reset(3);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("post_rst_no_push", 32'(MB_FIFO_PUSH_B), 32'h1);

`ifdef CLNK_PARITY_EN
      do_reset(1);
      step(1'b1, 1'b0, 1'b0, 16'h0007, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0);
      chk("par_0007", 32'(PAR_OUT), 32'h1);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("par_0003", 32'(PAR_OUT), 32'h0);
      step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      chk("par_hold", 32'(PAR_OUT), 32'h0);
`endif

      // Randomized traffic: heavy back-pressure first, then mostly open link.
      do_reset(1);
      for (int i = 0; i < 1600; i++) begin
         logic fb;
         if (i == 1000) do_reset(2);
         fb = (i < 700) ? 1'($urandom_range(0, 9) < 4) : 1'($urandom_range(0, 9) < 9);
         step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), 16'($urandom), fb, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
